// File: rtl/fetch_queue.sv
// fetch_queue: FETCH_W-wide fetch stage. It issues pipelined imem requests, tracks in-flight PCs,
// and buffers returned instructions for decode. Optional perf counters: define FETCH_QUEUE_PERF_EN.
module fetch_queue #(
   parameter int              FETCH_W   = 2,
   parameter int              PC_W      = 32,
   parameter int              INSTR_W   = 32,
   parameter int              FQ_DEPTH  = 8,
   parameter int              MAX_OUTST = 2,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_en,
   input  logic                       redirect_en,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [PC_W-1:0]            imem_req_addr,
   input  logic                       imem_resp_valid,
   input  logic [FETCH_W*INSTR_W-1:0] imem_resp_data,
   output logic [FETCH_W-1:0]         id_valid,
   output logic [FETCH_W*PC_W-1:0]    id_pc,
   output logic [FETCH_W*INSTR_W-1:0] id_instr,
   input  logic                       id_ready
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]                perf_req_cnt,
   output logic [31:0]                perf_drop_cnt,
   output logic [31:0]                perf_starve_cnt
`endif
);

   localparam int          PTR_W   = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int          CNT_W   = $clog2(FQ_DEPTH + 1);
   localparam int          OUT_W   = $clog2(MAX_OUTST + 1);
   localparam int          PF_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned DEPTH_U = FQ_DEPTH;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
      int unsigned s;
      s = (32'(p) + k) % DEPTH_U;
      return s[PTR_W-1:0];
   endfunction

   function automatic logic [PF_W-1:0] pf_inc(input logic [PF_W-1:0] p);
      if (32'(p) == 32'(MAX_OUTST - 1)) begin
         return '0;
      end else begin
         return p + PF_W'(1);
      end
   endfunction

   logic [PC_W-1:0]    pc_r;
   logic [PTR_W-1:0]   head_r, tail_r;
   logic [CNT_W-1:0]   count_r;
   logic [OUT_W-1:0]   outst_r, drop_r;
   logic [PF_W-1:0]    pf_rd_r, pf_wr_r;
   logic [PC_W-1:0]    pf_mem_r   [MAX_OUTST];
   logic [PC_W-1:0]    fq_pc_r    [FQ_DEPTH];
   logic [INSTR_W-1:0] fq_instr_r [FQ_DEPTH];

   logic               req_ok_s, accept_s, discard_s, push_s, pop_s;
   logic [31:0]        free_s, need_s;
   logic [CNT_W-1:0]   pop_n_s, count_nxt_s;
   logic [OUT_W-1:0]   outst_nxt_s, drop_nxt_s;

   // Request gating reserves queue space for every response still in flight.
   always_comb begin
      free_s    = 32'(FQ_DEPTH) - 32'(count_r);
      need_s    = (32'(outst_r) + 32'd1) * 32'(FETCH_W);
      req_ok_s  = fetch_en && !redirect_en && (32'(outst_r) < 32'(MAX_OUTST)) && (free_s >= need_s);
      accept_s  = req_ok_s && imem_req_ready;
      discard_s = redirect_en || (drop_r != '0);
      push_s    = imem_resp_valid && !discard_s;
      pop_s     = id_ready && (count_r != '0) && !redirect_en;
      pop_n_s   = (32'(count_r) < 32'(FETCH_W)) ? count_r : CNT_W'(FETCH_W);

      if (redirect_en) begin
         count_nxt_s = '0;
      end else begin
         count_nxt_s = count_r + (push_s ? CNT_W'(FETCH_W) : '0) - (pop_s ? pop_n_s : '0);
      end

      case ({accept_s, imem_resp_valid})
         2'b10:   outst_nxt_s = outst_r + OUT_W'(1);
         2'b01:   outst_nxt_s = outst_r - OUT_W'(1);
         default: outst_nxt_s = outst_r;
      endcase

      // Everything still in flight after a redirect belongs to the old stream.
      if (redirect_en) begin
         drop_nxt_s = outst_nxt_s;
      end else if (imem_resp_valid && (drop_r != '0)) begin
         drop_nxt_s = drop_r - OUT_W'(1);
      end else begin
         drop_nxt_s = drop_r;
      end
   end

   // Control state: fetch PC, queue pointers, in-flight and drop bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r    <= RESET_PC;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         outst_r <= '0;
         drop_r  <= '0;
         pf_rd_r <= '0;
         pf_wr_r <= '0;
      end else begin
         count_r <= count_nxt_s;
         outst_r <= outst_nxt_s;
         drop_r  <= drop_nxt_s;
         if (redirect_en) begin
            pc_r   <= redirect_pc & {{(PC_W-2){1'b1}}, 2'b00};
            head_r <= '0;
            tail_r <= '0;
         end else begin
            if (accept_s) pc_r <= pc_r + PC_W'(4 * FETCH_W);
            if (push_s)   tail_r <= ptr_add(tail_r, FETCH_W);
            if (pop_s)    head_r <= ptr_add(head_r, 32'(pop_n_s));
         end
         if (accept_s)        pf_wr_r <= pf_inc(pf_wr_r);
         if (imem_resp_valid) pf_rd_r <= pf_inc(pf_rd_r);
      end
   end

   // Storage arrays: in-flight PCs and queued instruction/PC pairs.
   always_ff @(posedge clk) begin
      if (accept_s) pf_mem_r[pf_wr_r] <= pc_r;
      if (push_s) begin
         for (int i = 0; i < FETCH_W; i++) begin
            fq_pc_r[ptr_add(tail_r, i)]    <= pf_mem_r[pf_rd_r] + PC_W'(4 * i);
            fq_instr_r[ptr_add(tail_r, i)] <= imem_resp_data[i*INSTR_W +: INSTR_W];
         end
      end
   end

   // Decode lanes read straight from the queue head.
   always_comb begin
      id_valid = '0;
      id_pc    = '0;
      id_instr = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         id_valid[i]                 = (32'(count_r) > 32'(i)) && !redirect_en;
         id_pc[i*PC_W +: PC_W]       = fq_pc_r[ptr_add(head_r, i)];
         id_instr[i*INSTR_W +: INSTR_W] = fq_instr_r[ptr_add(head_r, i)];
      end
   end

   assign imem_req_valid = req_ok_s;
   assign imem_req_addr  = pc_r;

`ifdef FETCH_QUEUE_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_req_cnt    <= 32'd0;
         perf_drop_cnt   <= 32'd0;
         perf_starve_cnt <= 32'd0;
      end else begin
         if (accept_s && (perf_req_cnt != 32'hFFFF_FFFF))
            perf_req_cnt <= perf_req_cnt + 32'd1;
         if (imem_resp_valid && discard_s && (perf_drop_cnt != 32'hFFFF_FFFF))
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
         if (id_ready && (id_valid == '0) && (perf_starve_cnt != 32'hFFFF_FFFF))
            perf_starve_cnt <= perf_starve_cnt + 32'd1;
      end
   end
`endif

   fetch_queue_chk #(.OUT_W(OUT_W)) u_chk (
      .clk        (clk),
      .reset      (reset),
      .resp_valid (imem_resp_valid),
      .outst      (outst_r)
   );

endmodule

// fetch_queue_chk: simulation checks on the imem response stream.
module fetch_queue_chk #(
   parameter int OUT_W = 2
) (
   input logic             clk,
   input logic             reset,
   input logic             resp_valid,
   input logic [OUT_W-1:0] outst
);
   resp_needs_request: assert property (@(posedge clk) disable iff (reset) !(resp_valid && (outst == '0)));
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue
Overview:
- Parametrised N-wide instruction fetch stage with a decoupling fetch queue between instruction memory and decode.
- Issues pipelined requests over a valid/ready imem interface, with up to MAX_OUTST requests in flight.
- Buffers returned instructions with their PCs and delivers up to FETCH_W per cycle to decode under a valid/ready handshake.
- On redirect, flushes the queue and discards stale in-flight responses.

Parameters:
FETCH_W, 2, instructions per imem request and per decode cycle (power of 2, >=1)
PC_W, 32, PC width
INSTR_W, 32, instruction width
FQ_DEPTH, 8, queue entries, one instruction each (power of 2, >= FETCH_W)
MAX_OUTST, 2, maximum in-flight imem requests (>=1)
RESET_PC, 0, PC after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_en  in  1  permit new imem requests
redirect_en  in  1  flush and restart at redirect_pc
redirect_pc  in  PC_W  new fetch PC; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_W  base address; memory returns words at addr, addr+4, ..., addr+4*(FETCH_W-1)
imem_resp_valid  in  1  response beat; one per accepted request, in order, at least 1 cycle after acceptance
imem_resp_data  in  FETCH_W*INSTR_W  lane i = bits [i*INSTR_W +: INSTR_W]
id_valid  out  FETCH_W  lane i valid; lanes are contiguous from lane 0
id_pc  out  FETCH_W*PC_W  per-lane PC
id_instr  out  FETCH_W*INSTR_W  per-lane instruction
id_ready  in  1  decode consumes all valid lanes this cycle

Behaviour:
- Reset (async): pc_reg=RESET_PC; queue count=0; outstanding=0; drop_cnt=0; pc FIFO empty; imem_req_valid=0; id_valid=0. id_pc and id_instr are don't-care while invalid.
- Request:
  - imem_req_valid = fetch_en && !redirect_en && outstanding<MAX_OUTST && (FQ_DEPTH-count) >= (outstanding+1)*FETCH_W.
  - The free-space check reserves room for every in-flight response, so the queue never overflows and memory is never back-pressured on responses.
  - imem_req_addr = pc_reg.
  - On valid&&ready: push pc_reg into the in-flight PC FIFO (depth MAX_OUTST); pc_reg += 4*FETCH_W (mod 2^PC_W, wraps silently); outstanding++.
- Response: on imem_resp_valid, pop the PC FIFO and outstanding--.
  - If drop_cnt>0: discard the data and decrement drop_cnt.
  - Otherwise: push FETCH_W entries, lane i with PC = popped PC + 4*i.
  - Data becomes visible on id_* the next cycle (1-cycle queue latency).
- Request accept and response in the same cycle: outstanding unchanged; the PC FIFO pushes and pops.
- Decode output:
  - id_valid[i] = (count > i) && !redirect_en.
  - Lanes are read combinationally from queue head .. head+FETCH_W-1, wrapping modulo FQ_DEPTH.
  - On id_ready with a nonzero id_valid: pop min(count, FETCH_W). id_ready with no valid lanes has no effect.
  - Push and pop in the same cycle are allowed. The request free-space check uses count before the pop.
- Redirect (cycle T):
  - Queue count becomes 0; pc_reg becomes redirect_pc with [1:0]=0; any pop that cycle is ignored; no request is issued.
  - drop_cnt becomes outstanding minus 1 if a response arrives at T (that response is discarded regardless).
  - drop_cnt accumulates correctly if a redirect occurs while drop_cnt>0, because it always equals the remaining in-flight requests.
  - First request to redirect_pc may be issued at T+1.
- fetch_en=0: no new requests. In-flight responses still complete, and the queue still drains to decode.
- Assertion (sim only): imem_resp_valid with outstanding==0 is an error.

Optional Feature:
FETCH_QUEUE_PERF_EN
- When defined, adds three 32-bit saturating output counters, cleared by reset:
  - perf_req_cnt: accepted requests.
  - perf_drop_cnt: discarded responses.
  - perf_starve_cnt: cycles with id_ready=1 and id_valid=0.
- When undefined, these ports and their logic are absent.

Test Plan:
- Reset, fetch_en=1, ready=1, 1-cycle memory, id_ready=1 -> requests to 0x0, 0x8, 0x10...; first id_valid=2'b11 with PCs 0x0/0x4 two cycles after the first accept; steady 2 instructions/cycle.
- id_ready=0 with continuous fetch -> exactly 8 entries filled; imem_req_valid drops once free space < (outstanding+1)*2; no entry is lost when id_ready returns.
- Redirect to 0x103 with 2 requests in flight -> both responses discarded (drop_cnt 2->0); next request addr=0x100; first delivered PC=0x100.
- Response arrives in the same cycle as a redirect -> that response is discarded, and only the remaining in-flight response is dropped.
- Odd count (count=1, FETCH_W=2) -> id_valid=2'b01; pop of 1 leaves count=0.
- pc_reg=0xFFFFFFF8 -> next request addr=0x0 (wrap).
